face_classifier_dot_acc: RTL and testbench

- Downstream consumer of the 12-bit signed truncating multiplier stage in the face classifier datapath.
- Accepts a stream of (pixel, weight) pairs and forms each 12-bit wrapped product with the same arithmetic as the multiplier stage.
- Accumulates the products into a saturating signed dot product per feature vector, then presents the result on a valid/ready output to the classifier decision logic.

---
 rtl/face_classifier_pkg.sv | 24 ++
 rtl/face_classifier_dot_acc_prod.sv | 16 +
 rtl/face_classifier_dot_acc.sv | 174 +++++++++++++++++
 tb/tb_face_classifier_dot_acc.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/face_classifier_pkg.sv
// Shared definitions for the face classifier dot-product accumulator:
// default widths, the result-FSM state type and the saturation helper.
package face_classifier_pkg;

    localparam int DATA_W_DEF    = 12;
    localparam int ACC_W_DEF     = 24;
    localparam int MAX_TERMS_DEF = 64;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Overflow detector for a two's-complement add of equal-width operands.
    // Bit 1 flags a positive overflow (clamp to max), bit 0 a negative one (clamp to min).
    function automatic logic [1:0] sat_add(input logic aMsb, input logic bMsb, input logic sumMsb);
        logic [1:0] dir;
        dir    = 2'b00;
        dir[1] = !aMsb && !bMsb && sumMsb;
        dir[0] = aMsb && bMsb && !sumMsb;
        return dir;
    endfunction

endpackage

// File: rtl/face_classifier_dot_acc_prod.sv
// Combinational signed truncating multiplier: keeps only the low DATA_W bits
// of the product so it wraps exactly like the upstream multiplier stage.
module face_classifier_dot_acc_prod
    import face_classifier_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_pixel,
    input  logic [DATA_W-1:0] i_weight,
    output logic [DATA_W-1:0] o_prod
);

    // A DATA_W-wide multiply yields exactly the wrapped low bits of the full product.
    assign o_prod = $signed(i_pixel) * $signed(i_weight);

endmodule

// File: rtl/face_classifier_dot_acc.sv
// Streaming dot-product accumulator: multiplies (pixel, weight) pairs, sums
// them with signed saturation per feature vector and hands the result to the
// decision logic over a valid/ready interface.
module face_classifier_dot_acc
    import face_classifier_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic [DATA_W-1:0] in_weight,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_trunc
);

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [DATA_W-1:0] w_prod;
    logic              w_inFire;
    logic              w_outFire;
    logic              w_lastEff;
    logic [ACC_W-1:0]  w_prodExt;
    logic [ACC_W-1:0]  w_sum;
    logic [1:0]        w_satDir;
    logic [ACC_W-1:0]  w_satSum;

    logic              r_alive;
    logic              r_busy;
    logic [CNT_W-1:0]  r_inCount;
    logic              r_s1Valid;
    logic [DATA_W-1:0] r_s1Prod;
    logic              r_s1Last;
    logic              r_s1Trunc;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_s2Last;
    logic              r_s2Trunc;
    state_t            r_state;
    logic              r_outValid;
    logic [ACC_W-1:0]  r_outSum;
    logic [CNT_W-1:0]  r_outCount;
    logic              r_outOvf;
    logic              r_outTrunc;

    face_classifier_dot_acc_prod #(.DATA_W(DATA_W)) u_prod (
        .i_pixel  (in_pixel),
        .i_weight (in_weight),
        .o_prod   (w_prod)
    );

    // in_ready stays low in reset and from the closing beat until the result drains.
    assign in_ready  = r_alive && !r_busy;
    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = r_outValid && out_ready;
    assign w_lastEff = in_last || ((r_inCount + CNT_W'(1)) == CNT_W'(MAX_TERMS));

    assign w_prodExt = ACC_W'($signed(r_s1Prod));
    assign w_sum     = r_acc + w_prodExt;
    assign w_satDir  = sat_add(r_acc[ACC_W-1], w_prodExt[ACC_W-1], w_sum[ACC_W-1]);
    assign w_satSum  = w_satDir[1] ? SAT_MAX : (w_satDir[0] ? SAT_MIN : w_sum);

    assign out_valid = r_outValid;
    assign out_sum   = r_outSum;
    assign out_count = r_outCount;
    assign out_ovf   = r_outOvf;
    assign out_trunc = r_outTrunc;

    // Input side: count accepted beats of the open vector and block new beats once it is closed.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_alive   <= 1'b0;
            r_busy    <= 1'b0;
            r_inCount <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_inFire) begin
                if (w_lastEff) begin
                    r_inCount <= '0;
                    r_busy    <= 1'b1;
                end else begin
                    r_inCount <= r_inCount + CNT_W'(1);
                end
            end else if (w_outFire) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Stage 1: register the wrapped product and end-of-vector flags of each accepted beat.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Prod  <= '0;
            r_s1Last  <= 1'b0;
            r_s1Trunc <= 1'b0;
        end else begin
            r_s1Valid <= w_inFire;
            if (w_inFire) begin
                r_s1Prod  <= w_prod;
                r_s1Last  <= w_lastEff;
                r_s1Trunc <= w_lastEff && !in_last;
            end
        end
    end

    // Stage 2: saturating accumulate; the running sum is cleared once the result is taken.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_s2Last  <= 1'b0;
            r_s2Trunc <= 1'b0;
        end else begin
            r_s2Last  <= r_s1Valid && r_s1Last;
            r_s2Trunc <= r_s1Valid && r_s1Trunc;
            if (w_outFire) begin
                r_acc   <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (r_s1Valid) begin
                r_acc   <= w_satSum;
                r_count <= r_count + CNT_W'(1);
                r_ovf   <= r_ovf || (|w_satDir);
            end
        end
    end

    // Result FSM: publish the finished vector and hold it stable until the consumer accepts it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state    <= ACCUM;
            r_outValid <= 1'b0;
            r_outSum   <= '0;
            r_outCount <= '0;
            r_outOvf   <= 1'b0;
            r_outTrunc <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (r_s2Last) begin
                        r_outSum   <= r_acc;
                        r_outCount <= r_count;
                        r_outOvf   <= r_ovf;
                        r_outTrunc <= r_s2Trunc;
                        r_outValid <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_face_classifier_dot_acc.sv
// Self-checking bench for face_classifier_dot_acc built with a narrow
// accumulator and a short term limit so saturation and truncation are reachable.
module tb_face_classifier_dot_acc;

    localparam int DATA_W     = 12;
    localparam int ACC_W      = 12;
    localparam int MAX_TERMS  = 4;
    localparam int CNT_W      = $clog2(MAX_TERMS + 1);
    localparam int WAIT_LIMIT = 40;
    localparam int SUM_MAX    = (1 << (ACC_W - 1)) - 1;
    localparam int SUM_MIN    = -(1 << (ACC_W - 1));

    typedef struct {
        int sum;
        int count;
        bit ovf;
        bit trunc;
    } result_t;

    logic              clk = 1'b0;
    logic              rstN;
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] inPixel;
    logic [DATA_W-1:0] inWeight;
    logic              inLast;
    logic              outValid;
    logic              outReady;
    logic [ACC_W-1:0]  outSum;
    logic [CNT_W-1:0]  outCount;
    logic              outOvf;
    logic              outTrunc;

    int      total = 0;
    int      bad   = 0;
    result_t expQ[$];
    int      mAcc  = 0;
    int      mCount = 0;
    bit      mOvf  = 1'b0;

    always #5 clk = ~clk;

    face_classifier_dot_acc #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .MAX_TERMS (MAX_TERMS)
    ) dut (
        .ap_clk    (clk),
        .ap_rst_n  (rstN),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_pixel  (inPixel),
        .in_weight (inWeight),
        .in_last   (inLast),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_sum   (outSum),
        .out_count (outCount),
        .out_ovf   (outOvf),
        .out_trunc (outTrunc)
    );

    // One comparison point: counts it and reports any mismatch.
    task automatic checkOutput(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: wrapped 12-bit product, clamped running sum, vector closes on last or at the term limit.
    task automatic modelBeat(input int px, input int wt, input bit last, output bit ended);
        int p;
        int s;
        p = (px * wt) & 32'hFFF;
        if (p >= 2048) p -= 4096;
        s = mAcc + p;
        if (s > SUM_MAX) begin
            s = SUM_MAX;
            mOvf = 1'b1;
        end else if (s < SUM_MIN) begin
            s = SUM_MIN;
            mOvf = 1'b1;
        end
        mAcc = s;
        mCount++;
        ended = 1'b0;
        if (last || mCount == MAX_TERMS) begin
            expQ.push_back('{sum: mAcc, count: mCount, ovf: mOvf, trunc: !last});
            mAcc = 0;
            mCount = 0;
            mOvf = 1'b0;
            ended = 1'b1;
        end
    endtask

    task automatic modelReset();
        mAcc = 0;
        mCount = 0;
        mOvf = 1'b0;
    endtask

    // Offer one beat and return #1 after the edge that accepts it.
    task automatic applyStimulus(input int px, input int wt, input bit last, output bit ended);
        int waitCycles;
        waitCycles = 0;
        @(negedge clk);
        inValid  = 1'b1;
        inPixel  = DATA_W'(px);
        inWeight = DATA_W'(wt);
        inLast   = last;
        while (!inReady && waitCycles < WAIT_LIMIT) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("beat_accept_wait", waitCycles < WAIT_LIMIT, 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        modelBeat(px, wt, last, ended);
    endtask

    // Wait for a result, compare it with the model, optionally hold back-pressure while poking the input.
    task automatic receiveResult(input int holdCycles, input bit pokeInput);
        int      waitCycles;
        result_t exp;
        waitCycles = 0;
        outReady = 1'b0;
        @(negedge clk);
        while (!outValid && waitCycles < WAIT_LIMIT) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("result_wait", waitCycles < WAIT_LIMIT, 1);
        checkOutput("result_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
            exp = expQ.pop_front();
            checkOutput("out_sum", $signed(outSum), exp.sum);
            checkOutput("out_count", outCount, exp.count);
            checkOutput("out_ovf", outOvf, exp.ovf);
            checkOutput("out_trunc", outTrunc, exp.trunc);
            for (int i = 0; i < holdCycles; i++) begin
                if (pokeInput) begin
                    inValid  = 1'b1;
                    inPixel  = DATA_W'($urandom);
                    inWeight = DATA_W'($urandom);
                    inLast   = 1'(i);
                end
                @(negedge clk);
                checkOutput("hold_valid", outValid, 1);
                checkOutput("hold_sum", $signed(outSum), exp.sum);
                checkOutput("hold_in_ready", inReady, 0);
            end
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput("valid_after_handshake", outValid, 0);
        checkOutput("ready_after_handshake", inReady, 1);
    endtask

    // Global time bound so the run can never hang.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ended;
        rstN     = 1'b0;
        inValid  = 1'b0;
        inPixel  = '0;
        inWeight = '0;
        inLast   = 1'b0;
        outReady = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_in_ready", inReady, 0);
        checkOutput("rst_out_sum", outSum, 0);
        checkOutput("rst_out_count", outCount, 0);
        @(negedge clk);
        rstN = 1'b1;

        // Three-beat vector with exact latency checks and out_ready held high
        outReady = 1'b1;
        applyStimulus(2, 3, 1'b0, ended);
        applyStimulus(-4, 5, 1'b0, ended);
        applyStimulus(7, -1, 1'b1, ended);
        checkOutput("lat_edge_t", outValid, 0);
        checkOutput("lat_ready_drop", inReady, 0);
        @(posedge clk);
        #1;
        checkOutput("lat_edge_t1", outValid, 0);
        @(posedge clk);
        #1;
        checkOutput("lat_edge_t2", outValid, 1);
        checkOutput("vec3_sum", $signed(outSum), -21);
        checkOutput("vec3_count", outCount, 3);
        checkOutput("vec3_ovf", outOvf, 0);
        checkOutput("vec3_trunc", outTrunc, 0);
        if (expQ.size() != 0) void'(expQ.pop_front());
        @(posedge clk);
        #1;
        checkOutput("lat_edge_t3_valid", outValid, 0);
        checkOutput("lat_edge_t3_ready", inReady, 1);
        outReady = 1'b0;

        // Product wrap: 10000 keeps 0x710, -4096 wraps to 0
        applyStimulus(100, 100, 1'b1, ended);
        receiveResult(0, 1'b0);
        applyStimulus(-64, 64, 1'b1, ended);
        receiveResult(1, 1'b0);

        // Saturation at the positive rail
        for (int i = 0; i < 4; i++) applyStimulus(45, 45, i == 3, ended);
        receiveResult(0, 1'b0);

        // Term limit closes the vector; back-pressure holds the result while the input is poked
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1'b0, ended);
        receiveResult(5, 1'b1);
        applyStimulus(1, 1, 1'b0, ended);
        applyStimulus(1, 1, 1'b1, ended);
        receiveResult(0, 1'b0);

        // Asynchronous reset in the middle of a vector discards it
        applyStimulus(5, 5, 1'b0, ended);
        applyStimulus(6, 6, 1'b0, ended);
        #2;
        rstN = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_out_valid", outValid, 0);
        checkOutput("midrst_in_ready", inReady, 0);
        checkOutput("midrst_out_count", outCount, 0);
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_stale", outValid, 0);
        end
        applyStimulus(3, 3, 1'b1, ended);
        receiveResult(0, 1'b0);

        // Random vectors, lengths beyond the limit exercise truncation
        for (int v = 0; v < 25; v++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                int px;
                int wt;
                if ($urandom_range(0, 1) == 0) begin
                    px = int'($urandom_range(0, 4095)) - 2048;
                    wt = int'($urandom_range(0, 4095)) - 2048;
                end else begin
                    px = int'($urandom_range(0, 80)) - 40;
                    wt = int'($urandom_range(0, 80)) - 40;
                end
                applyStimulus(px, wt, b == len - 1, ended);
                if (ended) receiveResult(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
        end

        checkOutput("queue_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
